// File: rtl/i2c_slave_byte_ctl_pkg.sv
// Shared constants for the I2C slave byte controller: address width, general-call
// address, FSM state encodings and small bus helper functions.
package i2c_slave_byte_ctl_pkg;

    localparam int ADDR_W = 7;
    typedef logic [ADDR_W-1:0] i2c_addr_t;

    localparam i2c_addr_t GEN_CALL_ADDR = '0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_RX        = 3'd3;
    localparam logic [2:0] ST_RX_ACK    = 3'd4;
    localparam logic [2:0] ST_TX        = 3'd5;
    localparam logic [2:0] ST_TX_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    // Filtered level only follows the pad once two successive samples agree.
    function automatic logic filt_next(input logic cur, input logic smp_now, input logic smp_prev);
        return (smp_now == smp_prev) ? smp_now : cur;
    endfunction

    function automatic logic addr_hit(input i2c_addr_t rx_addr, input i2c_addr_t own);
        return (rx_addr == own) && (rx_addr != GEN_CALL_ADDR);
    endfunction

endpackage

// File: rtl/i2c_slave_byte_ctl_bus_filter.sv
// SCL/SDA input conditioning: 2-FF synchronizer, sample-tick glitch filter,
// edge detection and START/STOP detection on the filtered bus.
module i2c_slave_bus_filter
    import i2c_slave_byte_ctl_pkg::*;
(
    input  logic        sysclk_i,
    input  logic        nRst_i,
    input  logic [15:0] dfsr_cnt_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        tick_o,
    output logic        sda_f_o,
    output logic        scl_rise_o,
    output logic        scl_fall_o,
    output logic        start_o,
    output logic        stop_o
);

    logic [1:0]  scl_sync_q, sda_sync_q;
    logic [15:0] div_q;
    logic        scl_smp_q, sda_smp_q;
    logic        scl_f_q, sda_f_q;
    logic        scl_prev_q, sda_prev_q;
    logic        sda_rise, sda_fall;

    // >= keeps the divider sane if dfsr_cnt is lowered while counting.
    assign tick_o = (div_q >= dfsr_cnt_i);

    always_ff @(posedge sysclk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            div_q      <= '0;
            scl_smp_q  <= 1'b1;
            sda_smp_q  <= 1'b1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            div_q      <= tick_o ? '0 : div_q + 16'd1;
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
            if (tick_o) begin
                scl_smp_q <= scl_sync_q[1];
                sda_smp_q <= sda_sync_q[1];
                scl_f_q   <= filt_next(scl_f_q, scl_sync_q[1], scl_smp_q);
                sda_f_q   <= filt_next(sda_f_q, sda_sync_q[1], sda_smp_q);
            end
        end
    end

    assign sda_f_o    = sda_f_q;
    assign scl_rise_o = scl_f_q & ~scl_prev_q;
    assign scl_fall_o = ~scl_f_q & scl_prev_q;
    assign sda_rise   = sda_f_q & ~sda_prev_q;
    assign sda_fall   = ~sda_f_q & sda_prev_q;
    assign start_o    = sda_fall & scl_f_q;
    assign stop_o     = sda_rise & scl_f_q;

endmodule

// File: rtl/i2c_slave_byte_ctl.sv
// Byte-level I2C slave: address match, byte shift in/out, ACK/NACK drive.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low while a transmit byte is not ready.
module i2c_slave_byte_ctl
    import i2c_slave_byte_ctl_pkg::*;
(
    input  logic        sysclk_i,
    input  logic        nRst_i,
    input  logic        enable_i,
    input  logic [15:0] dfsr_cnt,
    input  logic [6:0]  slave_addr_i,
    input  logic        ack_en_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_req_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        addr_match_o,
    output logic        rw_o,
    output logic        start_det_o,
    output logic        stop_det_o,
    output logic        i2c_busy_o,
    output logic        master_nack_o,
    input  logic        scl_i,
    output logic        scl_o,
    output logic        scl_oen,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_oen
);

`ifdef I2C_SLAVE_STRETCH_EN
    localparam bit StretchEn = 1'b1;
`else
    localparam bit StretchEn = 1'b0;
`endif

    logic       tick, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] in_byte;
    logic       load_tx;

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic       sda_oen_q, sda_oen_d, scl_oen_q, scl_oen_d;
    logic       ack_phase_q, ack_phase_d, nack_q, nack_d;
    logic       stretch_q, stretch_d, rel_pend_q, rel_pend_d;
    logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, mnack_q, mnack_d;
    logic       start_q, start_d, stop_q, stop_d;
    logic       match_q, match_d, rw_q, rw_d, busy_q, busy_d;

    i2c_slave_bus_filter u_filter (
        .sysclk_i   (sysclk_i),
        .nRst_i     (nRst_i),
        .dfsr_cnt_i (dfsr_cnt),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .tick_o     (tick),
        .sda_f_o    (sda_f),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    assign in_byte = {shift_q[6:0], sda_f};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_oen_d   = sda_oen_q;
        scl_oen_d   = scl_oen_q;
        ack_phase_d = ack_phase_q;
        nack_d      = nack_q;
        stretch_d   = stretch_q;
        rel_pend_d  = rel_pend_q;
        match_d     = match_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        mnack_d     = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        load_tx     = 1'b0;

        case (state_q)
            ST_ADDR: if (scl_rise) begin
                shift_d   = in_byte;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    bit_cnt_d   = '0;
                    ack_phase_d = 1'b0;
                    if (addr_hit(in_byte[7:1], slave_addr_i)) begin
                        state_d = ST_ADDR_ACK;
                        match_d = 1'b1;
                        rw_d    = in_byte[0];
                    end else begin
                        state_d = ST_WAIT_STOP;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (scl_rise && ack_phase_q && rw_q) tx_req_d = 1'b1;
                // First falling edge starts the ACK, the second ends it.
                if (scl_fall) begin
                    if (!ack_phase_q) begin
                        ack_phase_d = 1'b1;
                        sda_oen_d   = 1'b0;
                    end else begin
                        ack_phase_d = 1'b0;
                        sda_oen_d   = 1'b1;
                        bit_cnt_d   = '0;
                        state_d     = rw_q ? ST_TX : ST_RX;
                        load_tx     = rw_q;
                    end
                end
            end
            ST_RX: if (scl_rise) begin
                shift_d   = in_byte;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    bit_cnt_d   = '0;
                    rx_data_d   = in_byte;
                    rx_valid_d  = 1'b1;
                    ack_phase_d = 1'b0;
                    state_d     = ST_RX_ACK;
                end
            end
            ST_RX_ACK: if (scl_fall) begin
                if (!ack_phase_q) begin
                    ack_phase_d = 1'b1;
                    nack_d      = !ack_en_i;
                    sda_oen_d   = !ack_en_i;
                end else begin
                    ack_phase_d = 1'b0;
                    sda_oen_d   = 1'b1;
                    state_d     = nack_q ? ST_WAIT_STOP : ST_RX;
                end
            end
            ST_TX: if (!stretch_q) begin
                if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oen_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_TX_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oen_d = shift_q[6];
                    end
                end
            end
            ST_TX_ACK: begin
                if (scl_rise) begin
                    if (!sda_f) begin
                        tx_req_d = 1'b1;
                    end else begin
                        mnack_d = 1'b1;
                        state_d = ST_WAIT_STOP;
                    end
                end
                if (scl_fall) begin
                    bit_cnt_d = '0;
                    state_d   = ST_TX;
                    load_tx   = 1'b1;
                end
            end
            default: ;
        endcase

        // Transmit byte latch point; bit 7 goes out with the latch.
        if (load_tx) begin
            if (!StretchEn || tx_valid_i) begin
                shift_d   = tx_data_i;
                sda_oen_d = tx_data_i[7];
            end else begin
                stretch_d = 1'b1;
                scl_oen_d = 1'b0;
            end
        end
        if (stretch_q && tx_valid_i) begin
            shift_d    = tx_data_i;
            sda_oen_d  = tx_data_i[7];
            stretch_d  = 1'b0;
            rel_pend_d = 1'b1;
        end
        if (rel_pend_q && tick) begin
            rel_pend_d = 1'b0;
            scl_oen_d  = 1'b1;
        end

        // START/STOP abort the byte in flight and suppress its strobe.
        if (start_det || stop_det) begin
            rx_data_d   = rx_data_q;
            rx_valid_d  = 1'b0;
            tx_req_d    = 1'b0;
            mnack_d     = 1'b0;
            sda_oen_d   = 1'b1;
            scl_oen_d   = 1'b1;
            stretch_d   = 1'b0;
            rel_pend_d  = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            match_d     = 1'b0;
            start_d     = start_det;
            stop_d      = stop_det;
            busy_d      = start_det;
            state_d     = start_det ? ST_ADDR : ST_IDLE;
        end

        if (!enable_i) begin
            state_d     = ST_IDLE;
            rx_data_d   = rx_data_q;
            rx_valid_d  = 1'b0;
            tx_req_d    = 1'b0;
            mnack_d     = 1'b0;
            start_d     = 1'b0;
            stop_d      = 1'b0;
            sda_oen_d   = 1'b1;
            scl_oen_d   = 1'b1;
            stretch_d   = 1'b0;
            rel_pend_d  = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            match_d     = 1'b0;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge sysclk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            sda_oen_q   <= 1'b1;
            scl_oen_q   <= 1'b1;
            ack_phase_q <= 1'b0;
            nack_q      <= 1'b0;
            stretch_q   <= 1'b0;
            rel_pend_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            mnack_q     <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            match_q     <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_oen_q   <= sda_oen_d;
            scl_oen_q   <= scl_oen_d;
            ack_phase_q <= ack_phase_d;
            nack_q      <= nack_d;
            stretch_q   <= stretch_d;
            rel_pend_q  <= rel_pend_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            mnack_q     <= mnack_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            match_q     <= match_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_o         = 1'b0;
    assign scl_o         = 1'b0;
    assign sda_oen       = sda_oen_q;
    assign scl_oen       = scl_oen_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_req_o      = tx_req_q;
    assign master_nack_o = mnack_q;
    assign start_det_o   = start_q;
    assign stop_det_o    = stop_q;
    assign addr_match_o  = match_q;
    assign rw_o          = rw_q;
    assign i2c_busy_o    = busy_q;

endmodule
